// File: rtl/kugelblitz_tx_pad.sv
// TX pad stage between the kugelblitz offload TX master and the CMAC TX AXIS input.
// Zero-pads short single-beat frames, zeroes disabled bytes, registers through a skid buffer.
module kugelblitz_tx_pad #(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH    = 1,
    parameter int unsigned MIN_FRAME_LEN = 60,
    parameter bit          PAD_ENABLE    = 1'b1
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [31:0]           stat_frame_count,
    output logic [31:0]           stat_pad_count
);

    if (DATA_WIDTH != 512) begin : g_bad_data_width
        $error("kugelblitz_tx_pad: DATA_WIDTH must be 512");
    end
    if (KEEP_WIDTH != DATA_WIDTH / 8) begin : g_bad_keep_width
        $error("kugelblitz_tx_pad: KEEP_WIDTH must be DATA_WIDTH/8");
    end
    if (MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > KEEP_WIDTH) begin : g_bad_min_len
        $error("kugelblitz_tx_pad: MIN_FRAME_LEN must be in 1..KEEP_WIDTH");
    end

    localparam logic [KEEP_WIDTH-1:0] PAD_MASK =
        {KEEP_WIDTH{1'b1}} >> (KEEP_WIDTH - MIN_FRAME_LEN);

    logic                  in_frame;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [KEEP_WIDTH-1:0] skid_keep;
    logic                  skid_last;
    logic [USER_WIDTH-1:0] skid_user;
    logic                  skid_pad;
    logic                  out_pad;

    logic [DATA_WIDTH-1:0] in_data;
    logic [KEEP_WIDTH-1:0] in_keep;
    logic                  in_pad;
    logic                  s_acc;
    logic                  m_acc;
    logic                  out_free;

    assign s_acc    = s_axis_tvalid && s_axis_tready;
    assign m_acc    = m_axis_tvalid && m_axis_tready;
    assign out_free = m_acc || !m_axis_tvalid;

    // Masking always uses the original tkeep so newly padded bytes come out as zero.
    always_comb begin
        in_data = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            in_data[8*k +: 8] = s_axis_tkeep[k] ? s_axis_tdata[8*k +: 8] : 8'h00;
        end
        in_keep = s_axis_tkeep;
        in_pad  = 1'b0;
        if (PAD_ENABLE && !in_frame && s_axis_tlast) begin
            in_keep = s_axis_tkeep | PAD_MASK;
            in_pad  = (s_axis_tkeep & PAD_MASK) != PAD_MASK;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            in_frame         <= 1'b0;
            s_axis_tready    <= 1'b0;
            skid_valid       <= 1'b0;
            skid_data        <= '0;
            skid_keep        <= '0;
            skid_last        <= 1'b0;
            skid_user        <= '0;
            skid_pad         <= 1'b0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata     <= '0;
            m_axis_tkeep     <= '0;
            m_axis_tlast     <= 1'b0;
            m_axis_tuser     <= '0;
            out_pad          <= 1'b0;
            stat_frame_count <= '0;
            stat_pad_count   <= '0;
        end else begin
            if (s_acc) begin
                in_frame <= !s_axis_tlast;
            end

            // s_axis_tready mirrors !skid_valid, so s_acc never coincides with a full skid.
            if (out_free) begin
                if (skid_valid) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= skid_data;
                    m_axis_tkeep  <= skid_keep;
                    m_axis_tlast  <= skid_last;
                    m_axis_tuser  <= skid_user;
                    out_pad       <= skid_pad;
                    skid_valid    <= 1'b0;
                    s_axis_tready <= 1'b1;
                end else if (s_acc) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= in_data;
                    m_axis_tkeep  <= in_keep;
                    m_axis_tlast  <= s_axis_tlast;
                    m_axis_tuser  <= s_axis_tuser;
                    out_pad       <= in_pad;
                    s_axis_tready <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                    s_axis_tready <= 1'b1;
                end
            end else if (s_acc) begin
                skid_valid    <= 1'b1;
                skid_data     <= in_data;
                skid_keep     <= in_keep;
                skid_last     <= s_axis_tlast;
                skid_user     <= s_axis_tuser;
                skid_pad      <= in_pad;
                s_axis_tready <= 1'b0;
            end else begin
                s_axis_tready <= !skid_valid;
            end

            if (m_acc && m_axis_tlast) begin
                stat_frame_count <= stat_frame_count + 32'd1;
                if (out_pad) begin
                    stat_pad_count <= stat_pad_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kugelblitz_tx_pad.sv
// Directed bench for kugelblitz_tx_pad: vector table plus backpressure,
// throughput and mid-frame reset sequences.
module tb_kugelblitz_tx_pad;

    logic         tx_clk;
    logic         tx_rst_n;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [0:0]   s_axis_tuser;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [0:0]   m_axis_tuser;
    logic [31:0]  stat_frame_count;
    logic [31:0]  stat_pad_count;

    int tests;
    int failed;
    logic [7:0] log_q[$];

    kugelblitz_tx_pad dut (
        .tx_clk           (tx_clk),
        .tx_rst_n         (tx_rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .stat_frame_count (stat_frame_count),
        .stat_pad_count   (stat_pad_count)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    always @(posedge tx_clk) begin
        if (m_axis_tvalid && m_axis_tready) log_q.push_back(m_axis_tdata[7:0]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        last;
        logic [63:0] keep;
        logic [7:0]  fill;
        logic        user;
        logic [63:0] exp_keep;
        int          exp_frames;
        int          exp_pads;
    } vec_t;

    vec_t vecs[7];

    // Byte k carries fill^k so misplaced bytes are visible.
    function automatic logic [511:0] mk(input logic [7:0] fill);
        logic [511:0] d;
        for (int k = 0; k < 64; k++) d[8*k +: 8] = fill ^ k[7:0];
        return d;
    endfunction

    function automatic logic [511:0] exp_data(input logic [7:0] fill, input logic [63:0] keep);
        logic [511:0] d;
        for (int k = 0; k < 64; k++) d[8*k +: 8] = keep[k] ? (fill ^ k[7:0]) : 8'h00;
        return d;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] fill, input logic [63:0] keep, input logic last,
                        input logic user);
        logic ok;
        @(negedge tx_clk);
        s_axis_tdata  = mk(fill);
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = s_axis_tready;
            @(posedge tx_clk);
            if (!ok) @(negedge tx_clk);
        end
        if (!ok) check("send_accept_timeout", 512'd0, 512'd1);
    endtask

    initial begin
        int bad;
        tests = 0;
        failed = 0;

        vecs[0] = '{1'b1, 64'h0000_0000_0000_03FF, 8'hAA, 1'b1, 64'h0FFF_FFFF_FFFF_FFFF, 0, 0};
        vecs[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1};
        vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h22, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1};
        vecs[3] = '{1'b1, 64'h0000_0000_0000_000F, 8'h33, 1'b0, 64'h0000_0000_0000_000F, 2, 1};
        vecs[4] = '{1'b1, 64'h0FFF_FFFF_FFFF_FFFF, 8'h44, 1'b1, 64'h0FFF_FFFF_FFFF_FFFF, 3, 1};
        vecs[5] = '{1'b1, 64'h07FF_FFFF_FFFF_FFFF, 8'h55, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 4, 1};
        vecs[6] = '{1'b1, 64'h0000_0000_0000_0001, 8'h66, 1'b1, 64'h0FFF_FFFF_FFFF_FFFF, 5, 2};

        tx_rst_n      = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;

        #12;
        check("rst_s_tready", 512'(s_axis_tready), 512'd0);
        check("rst_m_tvalid", 512'(m_axis_tvalid), 512'd0);
        check("rst_m_tdata", m_axis_tdata, 512'd0);
        check("rst_counts", 512'({stat_frame_count, stat_pad_count}), 512'd0);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        #1 check("rel_s_tready_low", 512'(s_axis_tready), 512'd0);
        @(posedge tx_clk);
        #1 check("rel_s_tready_high", 512'(s_axis_tready), 512'd1);

        // Vector table, m side always ready: each beat visible one edge after acceptance.
        foreach (vecs[i]) begin
            @(negedge tx_clk);
            s_axis_tdata  = mk(vecs[i].fill);
            s_axis_tkeep  = vecs[i].keep;
            s_axis_tlast  = vecs[i].last;
            s_axis_tuser  = vecs[i].user;
            s_axis_tvalid = 1'b1;
            @(posedge tx_clk);
            #1;
            check($sformatf("v%0d_valid", i), 512'(m_axis_tvalid), 512'd1);
            check($sformatf("v%0d_keep", i), 512'(m_axis_tkeep), 512'(vecs[i].exp_keep));
            check($sformatf("v%0d_data", i), m_axis_tdata, exp_data(vecs[i].fill, vecs[i].keep));
            check($sformatf("v%0d_last_user", i), 512'({m_axis_tlast, m_axis_tuser}),
                  512'({vecs[i].last, vecs[i].user}));
            check($sformatf("v%0d_frames", i), 512'(stat_frame_count), 512'(vecs[i].exp_frames));
            check($sformatf("v%0d_pads", i), 512'(stat_pad_count), 512'(vecs[i].exp_pads));
        end
        @(negedge tx_clk);
        s_axis_tvalid = 1'b0;
        @(posedge tx_clk);
        #1;
        check("tbl_frames", 512'(stat_frame_count), 512'd6);
        check("tbl_pads", 512'(stat_pad_count), 512'd3);
        check("tbl_idle_valid", 512'(m_axis_tvalid), 512'd0);

        // Backpressure: 3-beat frame against 5 stalled cycles.
        log_q.delete();
        @(negedge tx_clk);
        m_axis_tready = 1'b0;
        send(8'h80, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send(8'h81, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        #1 check("bp_s_tready_low", 512'(s_axis_tready), 512'd0);
        fork
            send(8'h82, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
            begin
                repeat (3) @(posedge tx_clk);
                #1 check("bp_stable", 512'({m_axis_tvalid, m_axis_tdata[7:0]}), 512'(9'h180));
                @(negedge tx_clk);
                m_axis_tready = 1'b1;
            end
        join
        @(negedge tx_clk);
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge tx_clk);
        #1;
        check("bp_count", 512'(log_q.size()), 512'd3);
        check("bp_order", 512'({log_q[0], log_q[1], log_q[2]}), 512'(24'h808182));
        check("bp_frames", 512'(stat_frame_count), 512'd7);

        // 1000 back-to-back single-beat frames.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge tx_clk);
            s_axis_tdata  = mk(i[7:0]);
            s_axis_tkeep  = 64'hFFFF_FFFF_FFFF_FFFF;
            s_axis_tlast  = 1'b1;
            s_axis_tvalid = 1'b1;
            if (!s_axis_tready) bad++;
            @(posedge tx_clk);
            #1;
            if (!(m_axis_tvalid && m_axis_tdata[7:0] == i[7:0])) bad++;
        end
        @(negedge tx_clk);
        s_axis_tvalid = 1'b0;
        @(posedge tx_clk);
        #1;
        check("tput_errors", 512'(bad), 512'd0);
        check("tput_frames", 512'(stat_frame_count), 512'd1007);
        check("tput_pads", 512'(stat_pad_count), 512'd3);

        // Reset mid-frame after the first beat.
        send(8'h99, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        #2 tx_rst_n = 1'b0;
        #1;
        check("mrst_m_tvalid", 512'(m_axis_tvalid), 512'd0);
        check("mrst_m_bus", 512'({m_axis_tdata[447:0], m_axis_tkeep}), 512'd0);
        check("mrst_counts", 512'({stat_frame_count, stat_pad_count}), 512'd0);
        check("mrst_s_tready", 512'(s_axis_tready), 512'd0);
        @(negedge tx_clk);
        s_axis_tvalid = 1'b0;
        tx_rst_n = 1'b1;
        @(posedge tx_clk);
        send(8'h5A, 64'h0000_0000_000F_FFFF, 1'b1, 1'b0);
        #1;
        check("mrst_pad_keep", 512'(m_axis_tkeep), 512'(64'h0FFF_FFFF_FFFF_FFFF));
        check("mrst_pad_data", m_axis_tdata, exp_data(8'h5A, 64'h0000_0000_000F_FFFF));
        @(negedge tx_clk);
        s_axis_tvalid = 1'b0;
        @(posedge tx_clk);
        #1;
        check("mrst_frames", 512'(stat_frame_count), 512'd1);
        check("mrst_pads", 512'(stat_pad_count), 512'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
